// File: rtl/dd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dd_pkg
//  Brief    : Shared types and constants for the double-dabble controller.
//  Revision : 1.0  initial release
// ============================================================================
package dd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADJ   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } dd_state_t;

    localparam int         BCD_W       = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd4;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    // Number of decimal digits needed to hold 2^width-1.
    function automatic int dd_min_digits(input int width);
        int v;
        int d;
        v = (1 << width) - 1;
        d = 0;
        while (v > 0) begin
            v = v / 10;
            d = d + 1;
        end
        return (d == 0) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module   : dd_digit_adj
//  Brief    : Single BCD digit add-3 adjust (digit > 4 -> digit + 3).
//  Revision : 1.0  initial release
// ============================================================================
module dd_digit_adj
    import dd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit > ADD3_THRESH) ? (i_digit + ADD3_VAL) : i_digit;

endmodule
`default_nettype wire

// File: rtl/dd_conv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dd_conv_ctrl
//  Brief    : Binary-to-BCD double-dabble sequencer with valid/ready in/out.
//             Define DD_FAST_ADJ_EN to fold the add-3 adjust into each shift.
//  Revision : 1.0  initial release
// ============================================================================
module dd_conv_ctrl
    import dd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
);

    localparam int c_BCDW = BCD_W * DIGITS;
    localparam int c_TOTW = c_BCDW + WIDTH;
    localparam int c_CNTW = $clog2(WIDTH + 1);

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "dd_conv_ctrl: WIDTH must be within 4..16");
    end
    if (DIGITS < dd_min_digits(WIDTH)) begin : g_bad_digits
        $fatal(1, "dd_conv_ctrl: DIGITS too small to hold 2^WIDTH-1");
    end

    dd_state_t           r_state;
    logic [c_TOTW-1:0]   r_work;
    logic [c_CNTW-1:0]   r_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [c_BCDW-1:0]   r_bcd_out;

    logic [c_BCDW-1:0]   w_adj_bcd;
    logic [c_BCDW-1:0]   w_bcd_src;
    logic [c_TOTW-1:0]   w_next_shift;
    logic [c_CNTW-1:0]   w_cnt_nxt;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        dd_digit_adj u_adj (
            .i_digit (r_work[WIDTH + BCD_W*gi +: BCD_W]),
            .o_digit (w_adj_bcd[BCD_W*gi +: BCD_W])
        );
    end

`ifdef DD_FAST_ADJ_EN
    // Shift operates on the adjusted digits, so no separate ADJ cycle is needed.
    assign w_bcd_src = w_adj_bcd;
`else
    assign w_bcd_src = r_work[c_TOTW-1:WIDTH];
`endif

    assign w_next_shift = {w_bcd_src[c_BCDW-2:0], r_work[WIDTH-1:0], 1'b0};
    assign w_cnt_nxt    = r_cnt + c_CNTW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_bcd_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_work     <= {{c_BCDW{1'b0}}, bin_in};
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef DD_FAST_ADJ_EN
                        r_state    <= SHIFT;
`else
                        r_state    <= ADJ;
`endif
                    end
                end
                ADJ: begin
                    r_work[c_TOTW-1:WIDTH] <= w_adj_bcd;
                    r_state                <= SHIFT;
                end
                SHIFT: begin
                    r_work <= w_next_shift;
                    r_cnt  <= w_cnt_nxt;
                    if (w_cnt_nxt == c_CNTW'(WIDTH)) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_bcd_out   <= w_next_shift[c_TOTW-1:WIDTH];
                    end else begin
`ifdef DD_FAST_ADJ_EN
                        r_state <= SHIFT;
`else
                        r_state <= ADJ;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign bcd_out   = r_bcd_out;

endmodule
`default_nettype wire

// File: tb/tb_dd_conv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dd_conv_ctrl
//  Brief    : Directed self-checking bench for dd_conv_ctrl (WIDTH=8, DIGITS=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dd_conv_ctrl;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    // Clock edges from the acceptance edge to the edge that raises out_valid.
`ifdef DD_FAST_ADJ_EN
    localparam int c_LAT = WIDTH;
`else
    localparam int c_LAT = 2 * WIDTH;
`endif

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    bin_in;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                busy;

    int vectors;
    int miscompares;

    dd_conv_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] ref_bcd(input int v);
        ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word, return edges-to-out_valid and the presented result.
    task automatic run_conv(input logic [7:0] val, output int lat, output logic [11:0] res);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        in_valid = 1'b1;
        bin_in   = val;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = bcd_out;
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; bin_in = 8'h55; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        vectors += 4;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (bcd_out !== 12'h000) begin miscompares++; $display("FAIL reset_bcd: got %h expected 000", bcd_out); end
        tick();
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_no_accept: busy=%b in_ready=%b expected busy=0 in_ready=1", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  vin [5]  = '{8'h00, 8'hFF, 8'h63, 8'h64, 8'h2A};
        logic [11:0] vexp [5] = '{12'h000, 12'h255, 12'h099, 12'h100, 12'h042};
        int lat;
        logic [11:0] res;
        for (int i = 0; i < 5; i++) begin
            run_conv(vin[i], lat, res);
            vectors += 2;
            if (res !== vexp[i]) begin miscompares++; $display("FAIL basic_bcd[%0h]: got %h expected %h", vin[i], res, vexp[i]); end
            if (lat !== c_LAT) begin miscompares++; $display("FAIL basic_latency[%0h]: got %0d expected %0d", vin[i], lat, c_LAT); end
            take_out();
            vectors += 2;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_release[%0h]: in_ready=%b out_valid=%b expected 1/0", vin[i], in_ready, out_valid);
            end
            if (bcd_out !== vexp[i]) begin miscompares++; $display("FAIL basic_retain[%0h]: got %h expected %h", vin[i], bcd_out, vexp[i]); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [11:0] res;
        run_conv(8'h7B, lat, res);
        vectors++;
        if (res !== 12'h123) begin miscompares++; $display("FAIL bp_bcd: got %h expected 123", res); end
        // A new word offered while DONE must not be taken.
        in_valid = 1'b1; bin_in = 8'h99;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || bcd_out !== 12'h123 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: out_valid=%b bcd=%h in_ready=%b expected 1/123/0", i, out_valid, bcd_out, in_ready);
            end
        end
        in_valid = 1'b0;
        take_out();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        in_valid = 1'b1; bin_in = 8'h2A;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        in_valid = 1'b1; bin_in = 8'h11;
        tick(); tick();
        in_valid = 1'b0;
        lat = 5;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        vectors += 2;
        if (bcd_out !== 12'h042) begin miscompares++; $display("FAIL ignore_bcd: got %h expected 042", bcd_out); end
        if (lat !== c_LAT) begin miscompares++; $display("FAIL ignore_latency: got %0d expected %0d", lat, c_LAT); end
        take_out();
        tick();
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_no_second: busy=%b in_ready=%b out_valid=%b expected 0/1/0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        logic [11:0] res;
        in_valid = 1'b1; bin_in = 8'hC8;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bcd_out !== 12'h000 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_state: out_valid=%b busy=%b bcd=%h in_ready=%b expected 0/0/000/1",
                     out_valid, busy, bcd_out, in_ready);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) break;
        end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_no_output: got %b expected 0", out_valid); end
        run_conv(8'h07, lat, res);
        vectors += 2;
        if (res !== 12'h007) begin miscompares++; $display("FAIL midrst_next_bcd: got %h expected 007", res); end
        if (lat !== c_LAT) begin miscompares++; $display("FAIL midrst_next_latency: got %0d expected %0d", lat, c_LAT); end
        take_out();
    endtask

    task automatic test_out_ready_idle();
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== 12'h007) begin
            miscompares++;
            $display("FAIL idle_out_ready: in_ready=%b out_valid=%b bcd=%h expected 1/0/007", in_ready, out_valid, bcd_out);
        end
    endtask

    task automatic test_sweep();
        int lat;
        logic [11:0] res;
        logic [11:0] exp_bcd;
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), lat, res);
            exp_bcd = ref_bcd(v);
            vectors += 2;
            if (res !== exp_bcd) begin miscompares++; $display("FAIL sweep_bcd[%0d]: got %h expected %h", v, res, exp_bcd); end
            if (lat !== c_LAT) begin miscompares++; $display("FAIL sweep_latency[%0d]: got %0d expected %0d", v, lat, c_LAT); end
            take_out();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; in_valid = 1'b0; bin_in = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignore_in_valid();
        test_mid_reset();
        test_out_ready_idle();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
